// File: rtl/sd_sector_writer_pkg.sv
// Shared types and bus map for the SD sector writer.
package sd_sector_writer_pkg;

  typedef enum logic [2:0] {
    SDW_IDLE       = 3'd0,
    SDW_WAIT_READY = 3'd1,
    SDW_ISSUE      = 3'd2,
    SDW_STREAM     = 3'd3,
    SDW_WAIT_DONE  = 3'd4,
    SDW_FIN        = 3'd5
  } sdw_state_e;

  // Byte-addressed bus map; the buffer window spans one full sector.
  localparam logic [15:0] Sdw_base   = 16'h4000;
  localparam logic [15:0] Sdw_addr   = 16'h4200;
  localparam logic [15:0] Sdw_write  = 16'h4204;
  localparam logic [15:0] Sdw_status = 16'h4208;

  function automatic logic [31:0] sdw_status_word(input logic [15:0] bytes_sent,
                                                  input logic err, input logic done,
                                                  input logic busy);
    return {13'd0, bytes_sent, err, done, busy};
  endfunction

endpackage

// File: rtl/sd_sector_ram.sv
// Simple dual-port 8-bit block RAM with registered read; shared with the read cache.
module sd_sector_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_rdata <= '0;
    else         r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sd_sector_writer.sv
// Streams a CPU-filled sector buffer into sd_controller, one byte per request.
// Optional watchdog on controller progress: define SD_WR_TIMEOUT_EN.
module sd_sector_writer
  import sd_sector_writer_pkg::*;
#(
  parameter int unsigned SECTOR_BYTES   = 512,
  parameter int unsigned IDX_W          = 9,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_buf_we,
  input  logic [IDX_W-1:0] i_buf_widx,
  input  logic [7:0]       i_buf_wdata,
  input  logic [IDX_W-1:0] i_buf_ridx,
  output logic [7:0]       o_buf_rdata,
  input  logic             i_addr_we,
  input  logic [31:0]      i_addr_wdata,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err,
  output logic [IDX_W:0]   o_bytes_sent,
  input  logic             i_sd_ready,
  input  logic             i_sd_ready_for_next_byte,
  output logic             o_sd_wr,
  output logic [31:0]      o_sd_address,
  output logic [7:0]       o_sd_din
);

  localparam logic [IDX_W:0] LastCount = (IDX_W+1)'(SECTOR_BYTES);

  sdw_state_e     r_state;
  logic           r_start_d, r_req_d, r_busy, r_done, r_err, r_sd_wr;
  logic [IDX_W:0] r_bytes_sent;
  logic [31:0]    r_sd_address;
  logic [7:0]     r_sd_din;
  logic [1:0]     r_stream_cnt;

  logic           w_buf_we, w_start_edge, w_req_edge, w_count, w_timeout;
  logic [IDX_W:0] w_sent_next;
  logic [7:0]     w_stream_rdata;

  assign w_buf_we     = i_buf_we && !r_busy;
  assign w_start_edge = i_start && !r_start_d;
  assign w_req_edge   = i_sd_ready_for_next_byte && !r_req_d;
  assign w_count      = (r_state == SDW_STREAM) && w_req_edge && (r_bytes_sent != LastCount);
  assign w_sent_next  = r_bytes_sent + (IDX_W+1)'(w_count);

  // Two copies written together: one read port for the bus, one for streaming.
  sd_sector_ram #(.DEPTH(SECTOR_BYTES), .AW(IDX_W)) u_ram_bus (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_buf_we),
    .i_waddr (i_buf_widx),
    .i_wdata (i_buf_wdata),
    .i_raddr (i_buf_ridx),
    .o_rdata (o_buf_rdata)
  );

  sd_sector_ram #(.DEPTH(SECTOR_BYTES), .AW(IDX_W)) u_ram_stream (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (w_buf_we),
    .i_waddr (i_buf_widx),
    .i_wdata (i_buf_wdata),
    .i_raddr (r_bytes_sent[IDX_W-1:0]),
    .o_rdata (w_stream_rdata)
  );

`ifdef SD_WR_TIMEOUT_EN
  logic [31:0] r_wdog;

  assign w_timeout = (r_wdog == 32'(TIMEOUT_CYCLES - 1));

  // Held at zero outside the waiting states, so every entry starts a fresh window.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wdog <= '0;
    end else if (r_state == SDW_IDLE || r_state == SDW_ISSUE || r_state == SDW_FIN ||
                 w_req_edge) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + 32'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= SDW_IDLE;
      r_start_d    <= 1'b0;
      r_req_d      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_sd_wr      <= 1'b0;
      r_bytes_sent <= '0;
      r_sd_address <= '0;
      r_sd_din     <= '0;
      r_stream_cnt <= '0;
    end else begin
      r_start_d <= i_start;
      r_req_d   <= i_sd_ready_for_next_byte;
      r_sd_wr   <= 1'b0;
      if (i_addr_we && !r_busy) r_sd_address <= i_addr_wdata;
      if (i_buf_we && r_busy)   r_err        <= 1'b1;

      unique case (r_state)
        SDW_IDLE: begin
          if (w_start_edge) begin
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_bytes_sent <= '0;
            r_busy       <= 1'b1;
            r_state      <= SDW_WAIT_READY;
          end
        end
        SDW_WAIT_READY: begin
          if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= SDW_FIN;
          end else if (i_sd_ready) begin
            r_sd_wr <= 1'b1;
            r_state <= SDW_ISSUE;
          end
        end
        SDW_ISSUE: begin
          r_sd_din     <= w_stream_rdata;
          r_stream_cnt <= '0;
          r_state      <= SDW_STREAM;
        end
        SDW_STREAM: begin
          r_sd_din     <= w_stream_rdata;
          r_bytes_sent <= w_sent_next;
          if (r_stream_cnt != 2'd2) r_stream_cnt <= r_stream_cnt + 2'd1;
          // A request coinciding with sd_ready is counted before completion is judged.
          if (w_sent_next == LastCount) begin
            r_state <= SDW_WAIT_DONE;
          end else if ((i_sd_ready && r_stream_cnt == 2'd2) || w_timeout) begin
            r_err   <= 1'b1;
            r_state <= SDW_FIN;
          end
        end
        SDW_WAIT_DONE: begin
          if (i_sd_ready) begin
            r_state <= SDW_FIN;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= SDW_FIN;
          end
        end
        SDW_FIN: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= SDW_IDLE;
        end
        default: r_state <= SDW_IDLE;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_bytes_sent = r_bytes_sent;
  assign o_sd_wr      = r_sd_wr;
  assign o_sd_address = r_sd_address;
  assign o_sd_din     = r_sd_din;

endmodule

// File: tb/tb_sd_sector_writer.sv
// Randomized bench for sd_sector_writer with a behavioural controller and buffer model.
module tb_sd_sector_writer;

  localparam int unsigned SectorBytes   = 512;
  localparam int unsigned IdxW          = 9;
  localparam int unsigned TimeoutCycles = 1000;

  logic            clk = 1'b0;
  logic            i_reset, i_buf_we, i_addr_we, i_start, i_sd_ready, i_rfnb;
  logic [IdxW-1:0] i_buf_widx, i_buf_ridx;
  logic [7:0]      i_buf_wdata;
  logic [31:0]     i_addr_wdata;
  logic [7:0]      o_buf_rdata, o_sd_din;
  logic            o_busy, o_done, o_err, o_sd_wr;
  logic [IdxW:0]   o_bytes_sent;
  logic [31:0]     o_sd_address;

  always #5 clk = ~clk;

  sd_sector_writer #(
    .SECTOR_BYTES   (SectorBytes),
    .IDX_W          (IdxW),
    .TIMEOUT_CYCLES (TimeoutCycles)
  ) dut (
    .i_clk                    (clk),
    .i_reset                  (i_reset),
    .i_buf_we                 (i_buf_we),
    .i_buf_widx               (i_buf_widx),
    .i_buf_wdata              (i_buf_wdata),
    .i_buf_ridx               (i_buf_ridx),
    .o_buf_rdata              (o_buf_rdata),
    .i_addr_we                (i_addr_we),
    .i_addr_wdata             (i_addr_wdata),
    .i_start                  (i_start),
    .o_busy                   (o_busy),
    .o_done                   (o_done),
    .o_err                    (o_err),
    .o_bytes_sent             (o_bytes_sent),
    .i_sd_ready               (i_sd_ready),
    .i_sd_ready_for_next_byte (i_rfnb),
    .o_sd_wr                  (o_sd_wr),
    .o_sd_address             (o_sd_address),
    .o_sd_din                 (o_sd_din)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned wr_cycles = 0;
  logic [7:0]  ref_mem [SectorBytes];

  always @(negedge clk) if (o_sd_wr) wr_cycles++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic bus_write(input int idx, input logic [7:0] data, input bit model_it);
    i_buf_we    = 1'b1;
    i_buf_widx  = IdxW'(idx);
    i_buf_wdata = data;
    step();
    i_buf_we = 1'b0;
    if (model_it) ref_mem[idx] = data;
  endtask

  task automatic bus_read(input int idx, output logic [7:0] data);
    i_buf_ridx = IdxW'(idx);
    step();
    data = o_buf_rdata;
  endtask

  task automatic set_addr(input logic [31:0] a);
    i_addr_we    = 1'b1;
    i_addr_wdata = a;
    step();
    i_addr_we = 1'b0;
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic apply_reset();
    i_reset = 1'b1;
    repeat (2) step();
    i_reset    = 1'b0;
    i_sd_ready = 1'b1;
    i_rfnb     = 1'b0;
  endtask

  // act_kind: 0 none, 1 extra start + addr write, 2 bus write while busy, 3 reset.
  task automatic run_transfer(input string tag, input int n_req, input bit full,
                              input int extra, input int sp_min, input int sp_max,
                              input int act_at, input int act_kind,
                              input logic [31:0] exp_addr);
    logic [7:0]  snap [SectorBytes];
    int unsigned wr0;
    int          bad;
    bit          seen;
    snap = ref_mem;
    wr0  = wr_cycles;
    bad  = 0;
    i_sd_ready = 1'b1;
    pulse_start();
    check_eq({tag, ".busy_on_start"}, 32'(o_busy), 32'd1);
    check_eq({tag, ".done_cleared"}, 32'(o_done), 32'd0);
    check_eq({tag, ".bytes_cleared"}, 32'(o_bytes_sent), 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (o_sd_wr) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq({tag, ".wr_seen"}, 32'(seen), 32'd1);
    if (!seen) begin
      apply_reset();
      return;
    end
    i_sd_ready = 1'b0;
    check_eq({tag, ".address"}, o_sd_address, exp_addr);
    for (int k = 0; k < n_req + extra; k++) begin
      repeat ($urandom_range(sp_max, sp_min)) step();
      if (k < int'(SectorBytes) && o_sd_din !== snap[k]) begin
        if (bad == 0) check_eq({tag, ".first_bad_din"}, 32'(o_sd_din), 32'(snap[k]));
        bad++;
      end
      if (act_kind == 1 && k == act_at) pulse_start();
      if (act_kind == 1 && k == act_at + 10) set_addr(32'h0000_1234);
      if (act_kind == 2 && k == act_at) bus_write(5, 8'hAA, 1'b0);
      if (act_kind == 3 && k == act_at) begin
        i_reset = 1'b1;
        step();
        check_eq({tag, ".rst_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, ".rst_wr"}, 32'(o_sd_wr), 32'd0);
        check_eq({tag, ".rst_bytes"}, 32'(o_bytes_sent), 32'd0);
        check_eq({tag, ".rst_addr"}, o_sd_address, 32'd0);
        i_reset    = 1'b0;
        i_sd_ready = 1'b1;
        return;
      end
      i_rfnb = 1'b1;
      repeat (2) step();
      i_rfnb = 1'b0;
    end
    repeat (5) step();
    i_sd_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (!o_busy) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check_eq({tag, ".finished"}, 32'(seen), 32'd1);
    check_eq({tag, ".done"}, 32'(o_done), 32'd1);
    check_eq({tag, ".err"}, 32'(o_err), 32'(!full || act_kind == 2));
    check_eq({tag, ".bytes_sent"}, 32'(o_bytes_sent), full ? SectorBytes : 32'(n_req));
    check_eq({tag, ".wr_cycles"}, wr_cycles - wr0, 32'd1);
    check_eq({tag, ".din_errors"}, 32'(bad), 32'd0);
    check_eq({tag, ".address_end"}, o_sd_address, exp_addr);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [31:0] a;
    int          n;
    bit          full;
    i_reset = 1'b1; i_buf_we = 1'b0; i_addr_we = 1'b0; i_start = 1'b0;
    i_sd_ready = 1'b1; i_rfnb = 1'b0;
    i_buf_widx = '0; i_buf_ridx = '0; i_buf_wdata = '0; i_addr_wdata = '0;
    repeat (3) step();
    i_reset = 1'b0;
    step();
    check_eq("reset.busy", 32'(o_busy), 32'd0);
    check_eq("reset.done", 32'(o_done), 32'd0);
    check_eq("reset.err", 32'(o_err), 32'd0);
    check_eq("reset.bytes", 32'(o_bytes_sent), 32'd0);
    check_eq("reset.wr", 32'(o_sd_wr), 32'd0);
    check_eq("reset.addr", o_sd_address, 32'd0);
    check_eq("reset.din", 32'(o_sd_din), 32'd0);
    check_eq("reset.rdata", 32'(o_buf_rdata), 32'd0);

    for (int i = 0; i < int'(SectorBytes); i++) bus_write(i, 8'(i), 1'b1);
    bus_read(3, rd);
    check_eq("readback.3", 32'(rd), 32'h03);
    bus_read(511, rd);
    check_eq("readback.511", 32'(rd), 32'hFF);

    set_addr(32'h0000_0800);
    run_transfer("happy", 512, 1'b1, 0, 20, 20, 0, 0, 32'h800);
    run_transfer("start_busy", 512, 1'b1, 0, 10, 12, 50, 1, 32'h800);
    run_transfer("overrun", 512, 1'b1, 0, 10, 12, 30, 2, 32'h800);
    bus_read(5, rd);
    check_eq("overrun.readback5", 32'(rd), 32'(ref_mem[5]));
    run_transfer("short", 100, 1'b0, 0, 10, 12, 0, 0, 32'h800);
    run_transfer("reset_mid", 512, 1'b1, 0, 10, 12, 300, 3, 32'h800);
    set_addr(32'h0000_0900);
    run_transfer("after_reset", 512, 1'b1, 0, 10, 12, 0, 0, 32'h900);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(SectorBytes); i++) bus_write(i, 8'($urandom), 1'b1);
      a = $urandom;
      set_addr(a);
      full = 1'($urandom_range(1, 0));
      n    = full ? 512 : int'($urandom_range(511, 1));
      run_transfer($sformatf("rand%0d", r), n, full, full ? int'($urandom_range(2, 0)) : 0,
                   10, 14, 0, 0, a);
    end

`ifdef SD_WR_TIMEOUT_EN
    begin
      int  cnt;
      bit  seen;
      int unsigned wr0;
      wr0 = wr_cycles;
      i_sd_ready = 1'b1;
      pulse_start();
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (o_sd_wr) begin
          seen = 1'b1;
          break;
        end
        step();
      end
      check_eq("timeout.wr_seen", 32'(seen), 32'd1);
      i_sd_ready = 1'b0;
      for (int k = 0; k < 9; k++) begin
        repeat (10) step();
        i_rfnb = 1'b1;
        repeat (2) step();
        i_rfnb = 1'b0;
      end
      repeat (10) step();
      i_rfnb = 1'b1;
      cnt = 0;
      seen = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        step();
        cnt++;
        if (cnt == 2) i_rfnb = 1'b0;
        if (o_done) begin
          seen = 1'b1;
          break;
        end
      end
      check_eq("timeout.fired", 32'(seen), 32'd1);
      check_eq("timeout.window", 32'(cnt >= 998 && cnt <= 1002), 32'd1);
      check_eq("timeout.err", 32'(o_err), 32'd1);
      check_eq("timeout.bytes", 32'(o_bytes_sent), 32'd10);
      check_eq("timeout.wr_cycles", wr_cycles - wr0, 32'd1);
      i_sd_ready = 1'b1;
    end
`endif

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sd_sector_writer.md
Name: sd_sector_writer

Overview:
- Write-direction companion to the SD read cache at the top level.
- The CPU fills a 512-byte sector buffer over the memory-mapped bus, latches a sector address, then triggers a write.
- The block hands the sector to sd_controller (wr/din/ready_for_next_byte), one byte per controller request.
- Status (busy/done/error/bytes sent) is readable on the bus. Address decode stays in the top level.

Parameters:
- SECTOR_BYTES, 512, buffer depth and bytes per write (power of two).
- IDX_W, 9, log2(SECTOR_BYTES).
- TIMEOUT_CYCLES, 5000000, clk cycles allowed between byte requests (only with SD_WR_TIMEOUT_EN).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- buf_we  in  1  bus write strobe to sector buffer.
- buf_widx  in  IDX_W  buffer byte index for write.
- buf_wdata  in  8  byte to store.
- buf_ridx  in  IDX_W  buffer byte index for readback.
- buf_rdata  out  8  readback byte, 1-cycle latency.
- addr_we  in  1  latch sector address.
- addr_wdata  in  32  sector address.
- start  in  1  write trigger (level; rising edge acts).
- busy  out  1  transfer in progress.
- done  out  1  sticky: last transfer completed.
- err  out  1  sticky: short write, overrun or timeout.
- bytes_sent  out  IDX_W+1  bytes consumed in current/last transfer.
- sd_ready  in  1  controller idle.
- sd_ready_for_next_byte  in  1  controller byte request.
- sd_wr  out  1  write command pulse.
- sd_address  out  32  sector address to controller.
- sd_din  out  8  byte presented to controller.

Behaviour:
- Reset values:
  - Outputs: busy=0, done=0, err=0, bytes_sent=0, sd_wr=0, sd_address=0, sd_din=0, buf_rdata=0.
  - State: FSM=IDLE.
  - Buffer RAM contents are not cleared.
- Buffer: dual-port block RAM, SECTOR_BYTES x 8.
  - Bus port: write when buf_we; read registered (buf_rdata valid the cycle after buf_ridx).
  - buf_we while busy: write dropped, err set.
- addr_we: sd_address <= addr_wdata when not busy; ignored when busy.
- start: edge-detected internally (start && !start_d).
- FSM:
  - IDLE: on start edge → clear done, err, bytes_sent; busy=1; → WAIT_READY.
  - WAIT_READY: when sd_ready=1 → ISSUE.
  - ISSUE: sd_wr=1 for exactly one cycle; sd_din preloaded with buffer[0]; → STREAM.
  - STREAM: on each rising edge of sd_ready_for_next_byte (registered edge detect):
    - increment bytes_sent;
    - sd_din updates to buffer[bytes_sent] within 2 cycles, RAM latency included.
    - Controller requests are at least 8 clk apart, so data is always settled.
    - When bytes_sent reaches SECTOR_BYTES → WAIT_DONE.
    - If sd_ready returns high first, after at least 2 cycles in STREAM → err=1, → FIN (short write).
  - WAIT_DONE: when sd_ready=1 → FIN.
  - FIN: busy=0; done=1; → IDLE.
- Simultaneous events:
  - Start edge while busy: ignored.
  - Request edge in the same cycle sd_ready rises: count the byte first, then evaluate completion.
  - Requests beyond SECTOR_BYTES: ignored; bytes_sent saturates.
- bytes_sent width: IDX_W+1 (0..512), no wrap.
- Reset mid-transfer: immediate return to IDLE with reset values. The controller is reset by the same signal at the top level.

Optional Feature:
- Macro: SD_WR_TIMEOUT_EN.
- Defined:
  - A 32-bit watchdog counts clk cycles in WAIT_READY, STREAM and WAIT_DONE; it reloads on entry and on every request edge.
  - Reaching TIMEOUT_CYCLES → err=1, → FIN, sd_wr held 0.
- Undefined:
  - No counter; the FSM waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Shared package / header.vh additions:
  - state encoding constants SDW_IDLE..SDW_FIN;
  - bus addresses Sdw_base (buffer window), Sdw_addr, Sdw_write, Sdw_status.
- Status word layout: {bytes_sent, err, done, busy}.
- One sub-module: sd_sector_ram (simple dual-port 8-bit BRAM, registered read), reused for the read cache.

Test Plan:
- Happy path:
  - Stimulus: fill buffer[i]=i[7:0]; addr=0x00000800; start; controller model idles sd_ready, then issues 512 request pulses spaced 20 cycles.
  - Response: one sd_wr pulse; sd_address=0x800; sd_din sequence 00,01..FF,00..FF; bytes_sent=512; done=1, err=0 after sd_ready high.
- Start while busy:
  - Stimulus: second start edge at byte 50; addr_we 0x1234 at byte 60.
  - Response: no second sd_wr; sd_address stays 0x800; transfer completes normally.
- Overrun:
  - Stimulus: buf_we idx 5 data 0xAA during STREAM.
  - Response: buffer[5] unchanged on readback; err=1, done=1 at end.
- Short write:
  - Stimulus: controller raises sd_ready after 100 requests.
  - Response: busy=0, done=1, err=1, bytes_sent=100.
- Reset mid-stream:
  - Stimulus: reset at byte 300.
  - Response: next cycle busy=0, sd_wr=0, bytes_sent=0; a new start then transfers a full 512 bytes.
- Timeout (SD_WR_TIMEOUT_EN, TIMEOUT_CYCLES=1000):
  - Stimulus: controller stalls after byte 10.
  - Response: err=1, done=1 at 1000±2 cycles after the last request.
